// File: rtl/uart_tx_frame.sv
// UART 8N1 transmitter (optional even parity) triggered by the rising edge of a
// debounced request level; one frame per edge, edges during a frame are dropped.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          par;
    logic          transmit_d;
    logic          start;
    logic          bit_end;

    assign start   = transmit & ~transmit_d & (state == IDLE);
    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            transmit_d <= 1'b1;  // a button held through reset must not fire
            txd        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            transmit_d <= transmit;
            done       <= 1'b0;
            if (state != IDLE)
                cnt <= bit_end ? '0 : cnt + 1'b1;

            // txd is registered, so each transition loads the value of the next bit
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        shreg <= data;
                        par   <= ^data;
                        state <= START;
                        txd   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= {1'b0, shreg[7:1]};
                        if (idx == 3'd7) begin
                            idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                txd   <= par;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                            txd <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        txd   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a no-parity and an even-parity instance at
// 4 clocks per bit; directed presses push expected frames, a monitor checks them.
module tb_uart_tx_frame;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic [1:0] tx = 2'b00;
    logic [1:0] txd_a, busy_a, done_a;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          u;
        logic [10:0] frame;    // bit i = line level during bit period i
        int          ncyc;     // expected busy cycles
        bit          done_exp;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
        .clk(clk), .reset(reset), .transmit(tx[0]), .data(data),
        .txd(txd_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    uart_tx_frame #(.CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
        .clk(clk), .reset(reset), .transmit(tx[1]), .data(data),
        .txd(txd_a[1]), .busy(busy_a[1]), .done(done_a[1]));

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int u, input logic [10:0] frame, input int ncyc, input bit d);
        exp_t e;
        e.u = u; e.frame = frame; e.ncyc = ncyc; e.done_exp = d;
        exp_q.push_back(e);
    endtask

    // one-cycle request pulse; rising edge sampled at the posedge between the two negedges
    task automatic press(input int u, input logic [7:0] d);
        @(negedge clk);
        data  = d;
        tx[u] = 1'b1;
        @(negedge clk);
        tx[u] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (busy_a == 2'b00) ok = 1'b1;
        end
        chk(ok, "idle_timeout", {62'd0, busy_a}, 64'd0);
        repeat (5) @(negedge clk);
    endtask

    // entered on the first negedge with busy high; records txd until busy drops
    task automatic run_frame(input int u);
        logic [63:0] wav = '0;
        logic [63:0] ew = '0;
        int          n = 0;
        bit          dbad = 1'b0;
        exp_t        e;
        while (busy_a[u] && n < 64) begin
            wav[n] = txd_a[u];
            if (done_a[u]) dbad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk(exp_q.size() > 0, "unexpected_frame", 64'(u), 64'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < e.ncyc; i++) ew[i] = e.frame[i / C];
            chk(e.u == u, "frame_unit", 64'(u), 64'(e.u));
            chk(n == e.ncyc, "busy_len", 64'(n), 64'(e.ncyc));
            chk(wav == ew, "txd_wave", wav, ew);
            chk(!dbad, "done_early", 64'(dbad), 64'd0);
            chk(done_a[u] == e.done_exp, "done_pulse", 64'(done_a[u]), 64'(e.done_exp));
            chk(txd_a[u] == 1'b1, "txd_idle_after", 64'(txd_a[u]), 64'd1);
            @(negedge clk);
            chk(done_a[u] == 1'b0, "done_width", 64'(done_a[u]), 64'd0);
        end
    endtask

    initial begin : monitor
        logic [1:0] bprev = 2'b00;
        logic [1:0] rise;
        forever begin
            @(negedge clk);
            rise  = busy_a & ~bprev;
            bprev = busy_a;
            for (int u = 0; u < 2; u++)
                if (rise[u]) begin
                    run_frame(u);
                    bprev[u] = 1'b0;
                end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit low_seen;
        // reset state
        repeat (3) @(negedge clk);
        chk({txd_a[0], busy_a[0], done_a[0]} == 3'b100, "reset_state0", {61'd0, txd_a[0], busy_a[0], done_a[0]}, 64'h4);
        chk({txd_a[1], busy_a[1], done_a[1]} == 3'b100, "reset_state1", {61'd0, txd_a[1], busy_a[1], done_a[1]}, 64'h4);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // basic frame A5: 0,1,0,1,0,0,1,0,1,1
        push(0, 11'b1_1_10100101_0, 10 * C, 1'b1);
        press(0, 8'hA5);
        wait_idle();

        // parity frames: 07 has three ones -> parity 1; A5 has four ones -> parity 0
        push(1, 11'b1_1_00000111_0, 11 * C, 1'b1);
        press(1, 8'h07);
        wait_idle();
        push(1, 11'b1_0_10100101_0, 11 * C, 1'b1);
        press(1, 8'hA5);
        wait_idle();

        // all-zero and all-one bytes
        push(0, 11'b1_1_00000000_0, 10 * C, 1'b1);
        press(0, 8'h00);
        wait_idle();
        push(1, 11'b1_0_11111111_0, 11 * C, 1'b1);
        press(1, 8'hFF);
        wait_idle();

        // hold 200 cycles with a re-press mid-frame: one frame only
        push(0, 11'b1_1_10000001_0, 10 * C, 1'b1);
        @(negedge clk);
        data  = 8'h81;
        tx[0] = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 tx[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 tx[0] = 1'b1;
        repeat (180) @(posedge clk);
        // fresh edge after the frame: second frame
        push(0, 11'b1_1_01011010_0, 10 * C, 1'b1);
        #1 begin data = 8'h5A; tx[0] = 1'b0; end
        @(posedge clk);
        #1 tx[0] = 1'b1;
        @(posedge clk);
        #1 tx[0] = 1'b0;
        wait_idle();

        // data changes mid-frame are ignored
        push(0, 11'b1_1_00111100_0, 10 * C, 1'b1);
        @(negedge clk);
        data  = 8'h3C;
        tx[0] = 1'b1;
        @(posedge clk);
        #1 tx[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 data = 8'hFF;
        wait_idle();

        // reset sampled at edge N+18 (inside data bit 3): 18 busy cycles, no done
        push(0, 11'b1_1_10100101_0, 18, 1'b0);
        @(negedge clk);
        data  = 8'hA5;
        tx[0] = 1'b1;
        @(posedge clk);
        repeat (17) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (!txd_a[0] || busy_a[0]) low_seen = 1'b1;
        end
        chk(!low_seen, "no_frame_after_reset", 64'(low_seen), 64'd0);
        tx[0] = 1'b0;
        wait_idle();

        // button held through reset deassertion on both units
        @(negedge clk);
        reset = 1'b1;
        tx    = 2'b11;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (txd_a != 2'b11 || busy_a != 2'b00) low_seen = 1'b1;
        end
        chk(!low_seen, "held_through_reset", 64'(low_seen), 64'd0);
        tx = 2'b00;
        wait_idle();

        chk(exp_q.size() == 0, "queue_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
